product_accumulator: RTL and testbench

Downstream consumer of the 3x3 combinational multiplier's 6-bit product. Accepts products over a valid/ready handshake and sums COUNT of them, or fewer on flush. Presents each batch sum with beat count and sticky overflow flag over a second valid/ready handshake. Sits between the multiplier output register and the result sink (display or checker).

---
 rtl/product_accumulator_pkg.sv | 17 +
 rtl/product_accumulator.sv | 77 +++++++
 tb/tb_product_accumulator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: FSM state encodings and width helper shared by the
// product accumulator.
package product_accumulator_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT multiplier products (or fewer on flush) and
// presents each batch sum, beat count and sticky overflow over valid/ready.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int IN_W = 6,
    parameter int ACC_W = 10,
    parameter int COUNT = 8,
    localparam int CNT_W = clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t             state, state_nx;
    logic [ACC_W-1:0]   acc, sum, acc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ovf, ovf_nx, carry, beat, close;

    assign in_ready = rst_n && (state == ST_ACCUM);
    assign beat = in_valid && in_ready;
    assign {carry, sum} = {1'b0, acc} + (ACC_W + 1)'(in_data);
    assign acc_nx = beat ? sum : acc;
    assign cnt_nx = beat ? cnt + CNT_W'(1) : cnt;
    assign ovf_nx = ovf | (beat & carry);
    // A flush only closes a batch that will hold at least one beat.
    assign close = (state == ST_ACCUM) &&
                   ((beat && cnt_nx == CNT_W'(COUNT)) || (flush && (cnt != '0 || beat)));

    always_comb begin
        state_nx = state;
        if (state == ST_ACCUM)
            state_nx = close ? ST_HOLD : ST_ACCUM;
        else
            state_nx = out_ready ? ST_ACCUM : ST_HOLD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (close) begin
                out_sum   <= acc_nx;
                out_count <= cnt_nx;
                out_ovf   <= ovf_nx;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= acc_nx;
                cnt <= cnt_nx;
                ovf <= ovf_nx;
            end
            if (state == ST_HOLD && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vectors against a default instance and a
// narrow (ACC_W=6, COUNT=2) instance for overflow.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] d_in_data = '0, o_in_data = '0;
    logic       d_in_valid = 1'b0, o_in_valid = 1'b0;
    logic       d_flush = 1'b0, o_flush = 1'b0;
    logic       d_out_ready = 1'b1, o_out_ready = 1'b1;
    logic       d_in_ready, o_in_ready;
    logic [9:0] d_out_sum;
    logic [5:0] o_out_sum;
    logic [3:0] d_out_count;
    logic [1:0] o_out_count;
    logic       d_out_ovf, o_out_ovf, d_out_valid, o_out_valid;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    product_accumulator d (
        .clk(clk), .rst_n(rst_n), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .flush(d_flush), .out_sum(d_out_sum),
        .out_count(d_out_count), .out_ovf(d_out_ovf), .out_valid(d_out_valid),
        .out_ready(d_out_ready)
    );

    product_accumulator #(.ACC_W(6), .COUNT(2)) o (
        .clk(clk), .rst_n(rst_n), .in_data(o_in_data), .in_valid(o_in_valid),
        .in_ready(o_in_ready), .flush(o_flush), .out_sum(o_out_sum),
        .out_count(o_out_count), .out_ovf(o_out_ovf), .out_valid(o_out_valid),
        .out_ready(o_out_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int v);
        d_in_valid = 1'b1;
        d_in_data = 6'(v);
        step();
        d_in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int valid, input int sum, input int cnt, input int ovf);
        check({tag, "_valid"}, int'(d_out_valid), valid);
        check({tag, "_sum"}, int'(d_out_sum), sum);
        check({tag, "_count"}, int'(d_out_count), cnt);
        check({tag, "_ovf"}, int'(d_out_ovf), ovf);
    endtask

    initial begin
        step();
        check_out("reset", 0, 0, 0, 0);
        check("reset_in_ready", int'(d_in_ready), 0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", int'(d_in_ready), 1);

        // Full batch 0,7,...,49 -> 196
        for (int i = 0; i < 8; i++) begin
            beat(7 * i);
            if (i < 7) check("full_early_valid", int'(d_out_valid), 0);
        end
        check_out("full", 1, 196, 8, 0);
        check("full_hold_in_ready", int'(d_in_ready), 0);
        step();
        check("full_drain_valid", int'(d_out_valid), 0);
        check("full_drain_in_ready", int'(d_in_ready), 1);
        check("full_keep_sum", int'(d_out_sum), 196);

        // Backpressure: beats offered during HOLD must not be consumed
        d_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(7 * i);
        for (int i = 0; i < 5; i++) begin
            d_in_valid = 1'b1;
            d_in_data = 6'd5;
            step();
            check_out("bp_hold", 1, 196, 8, 0);
            check("bp_in_ready", int'(d_in_ready), 0);
        end
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        step();
        check("bp_drain_valid", int'(d_out_valid), 0);
        check("bp_drain_in_ready", int'(d_in_ready), 1);
        for (int i = 0; i < 8; i++) beat(1);
        check_out("bp_next", 1, 8, 8, 0);
        step();

        // Flush
        beat(6);
        beat(12);
        beat(20);
        d_flush = 1'b1;
        step();
        d_flush = 1'b0;
        check_out("flush3", 1, 38, 3, 0);
        step();
        d_flush = 1'b1;
        step();
        d_flush = 1'b0;
        check("flush_empty_valid", int'(d_out_valid), 0);
        check("flush_empty_in_ready", int'(d_in_ready), 1);
        beat(4);
        d_flush = 1'b1;
        beat(9);
        d_flush = 1'b0;
        check_out("flush_beat", 1, 13, 2, 0);
        step();

        // Reset mid-batch
        beat(49);
        beat(49);
        beat(49);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_out("rst_mid", 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            beat(1);
            if (i < 7) check("rst_mid_early_valid", int'(d_out_valid), 0);
        end
        check_out("rst_mid_batch", 1, 8, 8, 0);
        step();

        // Reset during HOLD
        d_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(2);
        check_out("rst_hold_pre", 1, 16, 8, 0);
        rst_n = 1'b0;
        step();
        check_out("rst_hold", 0, 0, 0, 0);
        check("rst_hold_in_ready_low", int'(d_in_ready), 0);
        rst_n = 1'b1;
        d_out_ready = 1'b1;
        step();
        check("rst_hold_in_ready", int'(d_in_ready), 1);
        check("rst_hold_no_valid", int'(d_out_valid), 0);

        // Overflow on the narrow instance: 49+49 = 98 -> 34, then 1+2 = 3
        o_in_valid = 1'b1;
        o_in_data = 6'd49;
        step();
        step();
        o_in_valid = 1'b0;
        check("ovf_valid", int'(o_out_valid), 1);
        check("ovf_sum", int'(o_out_sum), 34);
        check("ovf_count", int'(o_out_count), 2);
        check("ovf_flag", int'(o_out_ovf), 1);
        step();
        o_in_valid = 1'b1;
        o_in_data = 6'd1;
        step();
        o_in_data = 6'd2;
        step();
        o_in_valid = 1'b0;
        check("ovf2_valid", int'(o_out_valid), 1);
        check("ovf2_sum", int'(o_out_sum), 3);
        check("ovf2_flag", int'(o_out_ovf), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
